counter_bin_writer: RTL
=======================

COUNTER_BIN_WRITER -- requirements
Module: counter_bin_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, SRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 18, count/bin data width.
REQ-003 SHALL have parameter DEPTH, default 4096, number of SRAM words (≤ 2^ADDR_WIDTH).
REQ-004 SHALL have port i_clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port i_rstn  input  1  reset, asynchronous, active-high (1 = reset).
REQ-006 SHALL have port i_pulse  input  1  synchronous count event, one count per high cycle.
REQ-007 SHALL have port i_start  input  1  start acquisition (level sampled each clock).
REQ-008 SHALL have port i_stop  input  1  abort acquisition.
REQ-009 SHALL have port i_bin_len  input  32  bin length in clock cycles.
REQ-010 SHALL have port i_nbins  input  ADDR_WIDTH+1  bins to acquire; 0 = continuous ring mode.
REQ-011 SHALL have port o_addr  output  ADDR_WIDTH  SRAM write address (channel A).
REQ-012 SHALL have port o_write_enable  output  1  SRAM write strobe (channel A).
REQ-013 SHALL have port o_data  output  DATA_WIDTH  bin count to write.
REQ-014 SHALL have port o_busy  output  1  high while in RUN.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse at normal completion.
REQ-016 SHALL have port o_overflow  output  1  sticky: some bin saturated since last start.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-018 IDLE: i_start=1 and i_stop=0 SHALL latch i_bin_len (0 treated as 1) and i_nbins, clear bin counter, cycle timer, address and o_overflow, and enter RUN next cycle.
REQ-019 Start cycle T: first bin SHALL cover cycles T+1..T+L (L = latched bin length); bin k covers T+1+kL..T+(k+1)L.
REQ-020 RUN: each cycle with i_pulse=1 SHALL increment the bin count, saturating at 2^DATA_WIDTH-1; an increment attempted at saturation SHALL set o_overflow.
REQ-021 The bin count SHALL include a pulse on the bin's last cycle; a pulse on the first cycle of the next bin SHALL count toward that next bin.
REQ-022 In the cycle after a bin's last cycle, o_write_enable SHALL be 1 for exactly one cycle with o_data = final count and o_addr = bin index; otherwise o_write_enable=0.
REQ-023 Bin counter SHALL restart at 0 (or 1 if i_pulse on the new bin's first cycle) with no dead cycle between bins.
REQ-024 o_addr SHALL increment after each write; at DEPTH-1 it SHALL wrap to 0.
REQ-025 With latched nbins=N>0, after the N-th bin's last cycle the FSM SHALL enter DONE; the N-th write and o_done=1 SHALL occur in the same cycle; DONE SHALL return to IDLE next cycle.
REQ-026 N > DEPTH SHALL be accepted; addresses wrap per REQ-024 and later bins overwrite.
REQ-027 N=0 SHALL run continuously, wrapping per REQ-024, until i_stop.
REQ-028 i_stop=1 in RUN SHALL enter IDLE next cycle; the partial bin SHALL be discarded (no write); a write already due that cycle SHALL still be issued.
REQ-029 i_start during RUN or DONE SHALL be ignored; i_start and i_stop both high in IDLE SHALL stay IDLE.
REQ-030 o_busy SHALL be 1 exactly in RUN; i_bin_len/i_nbins changes during RUN SHALL have no effect.
REQ-031 o_overflow SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-032 i_rstn=1 SHALL asynchronously force IDLE, o_addr=0, o_write_enable=0, o_data=0, o_busy=0, o_done=0, o_overflow=0, counters 0.
REQ-033 Reset mid-RUN SHALL abort with no write issued; after release the block SHALL await a new i_start.

Verification
REQ-034 bin_len=4, nbins=3, start at T, pulses every cycle -> writes at T+5/T+9/T+13, addr 0/1/2, data 4/4/4, o_done at T+13, o_busy T+1..T+12.
REQ-035 bin_len=0, nbins=2, pulses at T+1 only -> writes at T+2 (addr 0, data 1) and T+3 (addr 1, data 0).
REQ-036 DATA_WIDTH=4, bin_len=20, nbins=1, pulse every cycle -> data 15, o_overflow=1, held after o_done.
REQ-037 nbins=0, bin_len=1, DEPTH=4 -> addrs 0,1,2,3,0,1 on consecutive cycles; i_stop -> IDLE, no o_done.
REQ-038 bin_len=10, stop at T+7 -> no write, o_busy low from T+8; start ignored mid-run; reset mid-bin -> all outputs 0 immediately.

Source files
------------

// File: rtl/counter_bin_writer.sv
// counter_bin_writer
// Time-binned event counter that streams one count per bin into an SRAM
// write port. Each bin lasts a programmable number of clock cycles; the
// final count of a bin is written the cycle after the bin closes, at an
// address that advances after every write and wraps at DEPTH-1.
// A finite number of bins ends with a one-cycle done pulse. A bin count of
// zero selects continuous ring mode, which runs until stopped.

module counter_bin_writer #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_pulse,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [31:0]           i_bin_len,
    input  logic [ADDR_WIDTH:0]   i_nbins,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_write_enable,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] COUNT_MAX  = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] COUNT_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH:0]   NBINS_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   NBINS_ZERO = {(ADDR_WIDTH+1){1'b0}};

    // Saturating increment: a full counter stays full.
    function automatic logic [DATA_WIDTH-1:0] sat_inc(input logic [DATA_WIDTH-1:0] value);
        if (value == COUNT_MAX) begin
            return COUNT_MAX;
        end else begin
            return value + COUNT_ONE;
        end
    endfunction

    // Next SRAM address, wrapping after the last usable word.
    function automatic logic [ADDR_WIDTH-1:0] addr_next(input logic [ADDR_WIDTH-1:0] value);
        if (value == ADDR_LAST) begin
            return ADDR_ZERO;
        end else begin
            return value + ADDR_ONE;
        end
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [31:0]             bin_len_r;
    logic [ADDR_WIDTH:0]     nbins_r;
    logic [31:0]             timer_r;
    logic [DATA_WIDTH-1:0]   count_r;
    logic [ADDR_WIDTH:0]     bins_done_r;

    logic                    in_run_s;
    logic                    last_cycle_s;
    logic                    final_bin_s;
    logic                    start_accept_s;
    logic                    sat_hit_s;
    logic [DATA_WIDTH-1:0]   count_upd_s;

    // Per-cycle bin bookkeeping: bin boundary, final bin, and updated count.
    always_comb begin
        in_run_s     = (state_r == RUN);
        last_cycle_s = in_run_s && (timer_r == (bin_len_r - 32'd1));
        final_bin_s  = last_cycle_s && (nbins_r != NBINS_ZERO)
                       && (bins_done_r == (nbins_r - NBINS_ONE));
        sat_hit_s    = in_run_s && i_pulse && (count_r == COUNT_MAX);
        if (in_run_s && i_pulse) begin
            count_upd_s = sat_inc(count_r);
        end else begin
            count_upd_s = count_r;
        end
    end

    // Next-state logic. Completing the last bin wins over a stop in the
    // same cycle, since the acquisition has finished normally.
    always_comb begin
        state_next_s   = state_r;
        start_accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_start && !i_stop) begin
                    state_next_s   = RUN;
                    start_accept_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (final_bin_s) begin
                    state_next_s = DONE;
                end else if (i_stop) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Run configuration, latched once per accepted start so that input
    // changes during an acquisition are ignored. A zero length means one cycle.
    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            bin_len_r <= 32'd1;
            nbins_r   <= NBINS_ZERO;
        end else if (start_accept_s) begin
            bin_len_r <= (i_bin_len == 32'd0) ? 32'd1 : i_bin_len;
            nbins_r   <= i_nbins;
        end
    end

    // Bin timer, bin counter and completed-bin tally. The counter restarts
    // at a bin boundary with no dead cycle; a partial bin is dropped on exit.
    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            timer_r     <= 32'd0;
            count_r     <= {DATA_WIDTH{1'b0}};
            bins_done_r <= NBINS_ZERO;
        end else if (start_accept_s) begin
            timer_r     <= 32'd0;
            count_r     <= {DATA_WIDTH{1'b0}};
            bins_done_r <= NBINS_ZERO;
        end else if (in_run_s) begin
            if (last_cycle_s || (state_next_s != RUN)) begin
                timer_r <= 32'd0;
                count_r <= {DATA_WIDTH{1'b0}};
            end else begin
                timer_r <= timer_r + 32'd1;
                count_r <= count_upd_s;
            end
            if (last_cycle_s) begin
                bins_done_r <= bins_done_r + NBINS_ONE;
            end
        end
    end

    // Write strobe, data, done pulse and busy flag, all registered.
    // A bin that closes in a stop cycle is complete and is still written.
    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            o_write_enable <= 1'b0;
            o_data         <= {DATA_WIDTH{1'b0}};
            o_done         <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            o_write_enable <= last_cycle_s;
            o_done         <= final_bin_s;
            o_busy         <= (state_next_s == RUN);
            if (last_cycle_s) begin
                o_data <= count_upd_s;
            end
        end
    end

    // Write address: advances after each write strobe; cleared on start.
    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            o_addr <= ADDR_ZERO;
        end else if (start_accept_s) begin
            o_addr <= ADDR_ZERO;
        end else if (o_write_enable) begin
            o_addr <= addr_next(o_addr);
        end
    end

    // Sticky overflow: set by any increment attempted at saturation,
    // held until the next accepted start.
    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            o_overflow <= 1'b0;
        end else if (start_accept_s) begin
            o_overflow <= 1'b0;
        end else if (sat_hit_s) begin
            o_overflow <= 1'b1;
        end
    end

endmodule
